// File: rtl/outmap_stager_if.sv
// Beat input and window output bundle shared by the writeback path, the stager and the compressor.
interface outmap_stager_if #(
    parameter int IN_BYTES = 8
);
    logic                     in_valid;
    logic [IN_BYTES-1:0][7:0] in_data;
    logic [3:0]               in_num;
    logic                     in_last;
    logic                     in_ready;
    logic [15:0][7:0]         outmap_data;
    logic [4:0]               outmap_data_valid_num;
    logic                     start;
    logic [4:0]               valid_taken_num;
    logic                     map_done;
    logic                     underflow_err;

    modport master (
        output in_valid, in_data, in_num, in_last, valid_taken_num,
        input  in_ready, outmap_data, outmap_data_valid_num, start, map_done, underflow_err
    );

    modport slave (
        input  in_valid, in_data, in_num, in_last, valid_taken_num,
        output in_ready, outmap_data, outmap_data_valid_num, start, map_done, underflow_err
    );
endinterface

// File: rtl/outmap_stager.sv
// Circular byte stager between PE writeback and the output-map compressor; exposes a 16-byte
// window that stays withheld until it is full or the map's last beat has arrived.
module outmap_stager #(
    parameter int DEPTH    = 32,
    parameter int IN_BYTES = 8
) (
    input logic            clk,
    input logic            rst_n,
    outmap_stager_if.slave bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int WIN = 16;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t          state, state_next;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count, count_next;
    logic            first_pending, underflow_q, map_done_q;
    logic            ready, accept, start_w;
    logic [4:0]      valid_num, pop_n;
    logic [3:0]      push_n;
    logic [WIN-1:0][7:0] window;

    assign accept     = bus.in_valid && ready;
    assign push_n     = !accept ? 4'd0
                      : (bus.in_num > 4'(IN_BYTES)) ? 4'(IN_BYTES) : bus.in_num;
    assign pop_n      = (bus.valid_taken_num > valid_num) ? valid_num : bus.valid_taken_num;
    assign count_next = count + CW'(push_n) - CW'(pop_n);
    assign start_w    = first_pending && (valid_num != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = bus.in_last ? DRAIN : FILL;
            FILL:    if (accept && bus.in_last) state_next = DRAIN;
            DRAIN:   if (count_next == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Partial windows stay hidden in FILL: the compressor reads a short count as end-of-map.
    always_comb begin
        ready     = 1'b0;
        valid_num = 5'd0;
        case (state)
            IDLE:  ready = 1'b1;
            FILL: begin
                ready     = (CW'(DEPTH) - count) >= CW'(IN_BYTES);
                valid_num = (count >= CW'(WIN)) ? 5'(WIN) : 5'd0;
            end
            DRAIN: valid_num = (count >= CW'(WIN)) ? 5'(WIN) : 5'(count);
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            first_pending <= 1'b0;
            underflow_q   <= 1'b0;
            map_done_q    <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + AW'(push_n);
            rd_ptr     <= rd_ptr + AW'(pop_n);
            count      <= count_next;
            map_done_q <= (state == DRAIN) && (count_next == '0);
            if (bus.valid_taken_num > valid_num) underflow_q <= 1'b1;
            if (state == IDLE && accept)                 first_pending <= 1'b1;
            else if (start_w || state_next == IDLE)      first_pending <= 1'b0;
        end
    end

    // NOTE: the byte store has no reset; stale bytes never leak because the window masks by valid_num.
    always_ff @(posedge clk) begin
        for (int k = 0; k < IN_BYTES; k++) begin
            if (k < int'(push_n)) mem[wr_ptr + AW'(k)] <= bus.in_data[k];
        end
    end

    always_comb begin
        window = '0;
        for (int k = 0; k < WIN; k++) begin
            window[k] = (k < int'(valid_num)) ? mem[rd_ptr + AW'(k)] : 8'h00;
        end
    end

    assign bus.in_ready              = ready;
    assign bus.outmap_data           = window;
    assign bus.outmap_data_valid_num = valid_num;
    assign bus.start                 = start_w;
    assign bus.map_done              = map_done_q;
    assign bus.underflow_err         = underflow_q;
endmodule

// File: tb/tb_outmap_stager.sv
// Directed bench for outmap_stager: windows, back-pressure, wrap streaming, short/empty maps,
// underflow and asynchronous reset, all against hand-computed expectations.
module tb_outmap_stager;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    int   cnt, next_in, next_out, ti, cyc, take, exp_vn;
    bit   drain, rdy, done;
    int   takes [3] = '{3, 7, 11};

    outmap_stager_if #(.IN_BYTES(8)) bus ();
    outmap_stager #(.DEPTH(32), .IN_BYTES(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid        = 1'b0;
        bus.in_data         = '0;
        bus.in_num          = 4'd0;
        bus.in_last         = 1'b0;
        bus.valid_taken_num = 5'd0;
    endtask

    task automatic beat(input int first, input int n, input bit last);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 8; k++) bus.in_data[k] = 8'(first + k);
        bus.in_num  = 4'(n);
        bus.in_last = last;
    endtask

    function automatic logic [127:0] win(input int first, input int n);
        logic [127:0] w;
        w = '0;
        for (int k = 0; k < 16; k++) if (k < n) w[k*8 +: 8] = 8'(first + k);
        return w;
    endfunction

    function automatic logic [7:0] f(input int n);
        return 8'((n * 7 + 3) & 255);
    endfunction

    initial begin
        rst_n = 1'b1;
        idle();
        #2 rst_n = 1'b0;
        step();
        step();
        check("rst_ready", bus.in_ready, 1);
        check("rst_vn", bus.outmap_data_valid_num, 0);
        check("rst_data", bus.outmap_data, 0);
        check("rst_start", bus.start, 0);
        check("rst_done", bus.map_done, 0);
        check("rst_uf", bus.underflow_err, 0);
        rst_n = 1'b1;

        // 40-byte map, full pops of 16 then drain of 8
        beat(1, 8, 0);
        check("t1_rdy0", bus.in_ready, 1);
        step();
        beat(9, 8, 0);
        check("t1_vn_partial", bus.outmap_data_valid_num, 0);
        check("t1_start_partial", bus.start, 0);
        step();
        beat(17, 8, 0);
        bus.valid_taken_num = 5'd16;
        check("t1_vn_w1", bus.outmap_data_valid_num, 16);
        check("t1_data_w1", bus.outmap_data, win(1, 16));
        check("t1_start_w1", bus.start, 1);
        check("t1_rdy_w1", bus.in_ready, 1);
        step();
        beat(25, 8, 0);
        bus.valid_taken_num = 5'd0;
        check("t1_vn_gap", bus.outmap_data_valid_num, 0);
        check("t1_start_gap", bus.start, 0);
        step();
        beat(33, 8, 1);
        bus.valid_taken_num = 5'd16;
        check("t1_data_w2", bus.outmap_data, win(17, 16));
        check("t1_start_w2", bus.start, 0);
        step();
        idle();
        bus.valid_taken_num = 5'd8;
        check("t1_vn_drain", bus.outmap_data_valid_num, 8);
        check("t1_data_drain", bus.outmap_data, win(33, 8));
        check("t1_rdy_drain", bus.in_ready, 0);
        check("t1_done_early", bus.map_done, 0);
        step();
        idle();
        check("t1_done", bus.map_done, 1);
        check("t1_vn_idle", bus.outmap_data_valid_num, 0);
        check("t1_rdy_idle", bus.in_ready, 1);
        step();
        check("t1_done_once", bus.map_done, 0);

        // back-pressure: no takes for 10 cycles while beats keep arriving
        beat(101, 8, 0);
        step();
        beat(109, 8, 0);
        check("t2_rdy8", bus.in_ready, 1);
        step();
        beat(117, 8, 0);
        check("t2_rdy16", bus.in_ready, 1);
        check("t2_start", bus.start, 1);
        step();
        beat(125, 8, 0);
        check("t2_rdy24", bus.in_ready, 1);
        step();
        beat(133, 8, 1);
        for (int c = 0; c < 6; c++) begin
            check("t2_rdy_full", bus.in_ready, 0);
            check("t2_vn_full", bus.outmap_data_valid_num, 16);
            step();
        end
        bus.valid_taken_num = 5'd16;
        check("t2_data_a", bus.outmap_data, win(101, 16));
        check("t2_rdy_still", bus.in_ready, 0);
        step();
        check("t2_rdy_freed", bus.in_ready, 1);
        check("t2_data_b", bus.outmap_data, win(117, 16));
        step();
        idle();
        bus.valid_taken_num = 5'd8;
        check("t2_vn_drain", bus.outmap_data_valid_num, 8);
        check("t2_data_c", bus.outmap_data, win(133, 8));
        step();
        idle();
        check("t2_done", bus.map_done, 1);

        // wrap streaming: 5-byte beats, takes cycling 3/7/11, starting in the map_done cycle
        cnt = 0; next_in = 0; next_out = 0; ti = 0; cyc = 0; drain = 0; done = 0;
        while (!done && cyc < 2000) begin
            exp_vn = drain ? ((cnt > 16) ? 16 : cnt) : ((cnt >= 16) ? 16 : 0);
            rdy    = !drain && (32 - cnt >= 8);
            take   = (takes[ti % 3] < exp_vn) ? takes[ti % 3] : exp_vn;
            bus.in_valid = (next_in < 200);
            for (int k = 0; k < 8; k++) bus.in_data[k] = f(next_in + k);
            bus.in_num          = 4'd5;
            bus.in_last         = (next_in == 195);
            bus.valid_taken_num = 5'(take);
            check("wrap_vn", bus.outmap_data_valid_num, exp_vn);
            check("wrap_rdy", bus.in_ready, rdy);
            for (int k = 0; k < take; k++) check("wrap_byte", bus.outmap_data[k], f(next_out + k));
            step();
            if (bus.in_valid && rdy) begin
                next_in += 5;
                cnt     += 5;
                if (next_in == 200) drain = 1;
            end
            cnt      -= take;
            next_out += take;
            if (take > 0) ti++;
            if (drain && cnt == 0) done = 1;
            cyc++;
        end
        idle();
        check("wrap_finished", done, 1);
        check("wrap_bytes", next_out, 200);
        check("wrap_done", bus.map_done, 1);
        check("wrap_uf", bus.underflow_err, 0);

        // short map of 3 bytes
        beat(161, 3, 1);
        check("t4_start_idle", bus.start, 0);
        step();
        idle();
        bus.valid_taken_num = 5'd3;
        check("t4_vn", bus.outmap_data_valid_num, 3);
        check("t4_start", bus.start, 1);
        check("t4_data", bus.outmap_data, win(161, 3));
        check("t4_rdy", bus.in_ready, 0);
        step();
        idle();
        check("t4_done", bus.map_done, 1);
        check("t4_start_gone", bus.start, 0);
        step();

        // over-take: 9 requested with 4 valid
        beat(200, 4, 1);
        step();
        idle();
        bus.valid_taken_num = 5'd9;
        check("t5_vn", bus.outmap_data_valid_num, 4);
        check("t5_uf_before", bus.underflow_err, 0);
        step();
        idle();
        check("t5_uf_set", bus.underflow_err, 1);
        check("t5_done", bus.map_done, 1);
        check("t5_vn_after", bus.outmap_data_valid_num, 0);
        step();
        step();
        step();
        check("t5_uf_sticky", bus.underflow_err, 1);

        // zero-byte final beat as the map's only beat
        beat(1, 0, 1);
        check("t7_rdy", bus.in_ready, 1);
        step();
        idle();
        check("t7_rdy_drain", bus.in_ready, 0);
        check("t7_vn", bus.outmap_data_valid_num, 0);
        check("t7_start", bus.start, 0);
        step();
        check("t7_done", bus.map_done, 1);
        check("t7_start_idle", bus.start, 0);
        step();
        check("t7_done_once", bus.map_done, 0);

        // asynchronous reset with 20 bytes buffered in FILL
        beat(50, 8, 0);
        step();
        beat(58, 8, 0);
        step();
        beat(66, 4, 0);
        step();
        idle();
        check("t6_vn_pre", bus.outmap_data_valid_num, 16);
        check("t6_data_pre", bus.outmap_data, win(50, 16));
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_rdy", bus.in_ready, 1);
        check("t6_rst_vn", bus.outmap_data_valid_num, 0);
        check("t6_rst_data", bus.outmap_data, 0);
        check("t6_rst_start", bus.start, 0);
        check("t6_rst_done", bus.map_done, 0);
        check("t6_rst_uf", bus.underflow_err, 0);
        step();
        rst_n = 1'b1;
        check("t6_no_done", bus.map_done, 0);
        beat(70, 15, 0);
        check("t6_rdy", bus.in_ready, 1);
        step();
        beat(78, 15, 1);
        check("t6_vn_partial", bus.outmap_data_valid_num, 0);
        step();
        idle();
        bus.valid_taken_num = 5'd16;
        check("t6_vn", bus.outmap_data_valid_num, 16);
        check("t6_start", bus.start, 1);
        check("t6_data", bus.outmap_data, win(70, 16));
        step();
        idle();
        check("t6_done", bus.map_done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
